uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, idle-high line.
//
// The asynchronous rx line is passed through a two-flop synchronizer and every
// decision is taken on the synchronized copy (rx_s). A falling edge on rx_s
// starts a frame. The start bit is re-checked half a bit later to reject
// glitches. The data bits and the stop bit are then sampled once per bit
// period, near the bit centre.
//
// Ports:
//   clk         - sole clock, rising edge
//   rst         - synchronous active-high reset
//   rx          - asynchronous serial input, idle high
//   data_o      - last correctly framed byte, held between valid_o pulses
//   valid_o     - one-cycle pulse when data_o is updated
//   frame_err_o - one-cycle pulse when the stop bit samples low
//   busy_o      - high whenever the receiver is not idle
module uart_rx #(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             rx_meta;
  logic             rx_s;

  // Synchronizer stage: both flops reset to the idle (high) line level so that
  // leaving reset never looks like a start-bit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Data shift stage: only bits that were sampled inside a frame reach data_o,
  // so this register needs no reset.
  always_ff @(posedge clk) begin
    if (state == DATA && cnt == BIT_LAST) begin
      shift[idx] <= rx_s;
    end
  end

  // Control stage: frame sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state  <= START;
            busy_o <= 1'b1;
          end
        end

        // Half a bit after the edge the line must still be low, otherwise the
        // edge was a glitch. From here on whole-bit counts land on bit centres.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            if (rx_s) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // idx wraps from 7 back to 0 as the last data bit is taken.
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A good stop bit returns straight to IDLE. This lets the start bit of
        // a back-to-back frame be seen without an idle gap.
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data_o  <= shift;
              valid_o <= 1'b1;
              state   <= IDLE;
              busy_o  <= 1'b0;
            end else begin
              frame_err_o <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A held-low line (break) is reported once. After that the receiver
        // waits for the line to go high.
        WAIT_HIGH: begin
          if (rx_s) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
//
// A small bit time keeps the whole run short. Each frame sent on rx records
// what the receiver owes for it in an expectation queue: either a byte or a
// framing error, plus the time of the start edge. A negedge monitor matches
// every output pulse against that queue and checks latency. It also checks
// that data_o holds between pulses.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  uart_rx #(.CLOCKS_PER_BAUD(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .frame_err_o(frame_err_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    longint     fall;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_ev;
  logic [7:0] model_data = 8'h00;
  longint     valid_times[$];
  int         n_valid = 0;
  int         n_err   = 0;

  task automatic check(input string name, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input longint act,
                             input longint lo, input longint hi);
    compared++;
    if (act < lo || act > hi) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Output monitor
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_data = 8'h00;
    end else begin
      check("valid_and_err_together", valid_o & frame_err_o, 0);
      if (valid_o || frame_err_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse_kind_valid", valid_o, 0);
          check("unexpected_pulse_kind_err", frame_err_o, 0);
        end else begin
          mon_ev = exp_q.pop_front();
          check("pulse_is_err", frame_err_o, mon_ev.is_err);
          check_range("latency", cyc - mon_ev.fall, LAT - 1, LAT + 1);
          if (valid_o) begin
            check("data_o", data_o, mon_ev.data);
            model_data = mon_ev.data;
            valid_times.push_back(cyc);
            n_valid++;
          end else begin
            check("data_hold_on_err", data_o, model_data);
            n_err++;
          end
        end
      end else begin
        check("data_hold", data_o, model_data);
      end
    end
  end

  task automatic bit_time();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame, starting right away. The caller must already be
  // 1 time unit after a rising edge. A bad stop bit can be stretched by
  // extra_low whole bit times. The line is then released high long enough
  // for the receiver to rearm.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low);
    ev_t e;
    e.is_err = !stop_ok;
    e.data   = b;
    e.fall   = cyc;
    exp_q.push_back(e);
    rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_time();
    end
    rx = stop_ok;
    bit_time();
    if (!stop_ok) begin
      repeat (extra_low) bit_time();
      rx = 1'b1;
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         extra_low;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_err;
  } vec_t;

  vec_t vecs[8];
  int   v0, e0;
  bit   busy_seen;

  initial begin
    vecs[0] = '{8'hFF, 1'b1, 0, 8'hFF, 1, 0};
    vecs[1] = '{8'h81, 1'b1, 0, 8'h81, 1, 0};
    vecs[2] = '{8'h5A, 1'b1, 0, 8'h5A, 1, 0};
    vecs[3] = '{8'hA5, 1'b0, 3, 8'h5A, 0, 1};
    vecs[4] = '{8'h3C, 1'b1, 0, 8'h3C, 1, 0};
    vecs[5] = '{8'h00, 1'b1, 0, 8'h00, 1, 0};
    vecs[6] = '{8'hA5, 1'b0, 0, 8'h00, 0, 1};
    vecs[7] = '{8'hC3, 1'b1, 0, 8'hC3, 1, 0};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data_o", data_o, 8'h00);
    check("reset_valid_o", valid_o, 0);
    check("reset_frame_err_o", frame_err_o, 0);
    check("reset_busy_o", busy_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(CPB);

    // Table-driven frames
    foreach (vecs[k]) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(vecs[k].data, vecs[k].stop_ok, vecs[k].extra_low);
      idle(2 * CPB);
      check($sformatf("row%0d_valid_count", k), n_valid - v0, vecs[k].exp_valid);
      check($sformatf("row%0d_err_count", k), n_err - e0, vecs[k].exp_err);
      check($sformatf("row%0d_data_o", k), data_o, vecs[k].exp_data);
      check($sformatf("row%0d_busy_idle", k), busy_o, 0);
      check($sformatf("row%0d_queue_drained", k), exp_q.size(), 0);
    end

    // Back-to-back frames with no idle gap
    valid_times.delete();
    send_frame(8'h81, 1'b1, 0);
    send_frame(8'h5A, 1'b1, 0);
    idle(2 * CPB);
    check("b2b_pulse_count", valid_times.size(), 2);
    if (valid_times.size() == 2)
      check_range("b2b_spacing", valid_times[1] - valid_times[0], 10 * CPB - 2, 10 * CPB + 2);
    check("b2b_last_data", data_o, 8'h5A);

    // Short low glitch on an idle line
    v0 = n_valid;
    e0 = n_err;
    busy_seen = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < HALF - 3; i++) begin
      @(posedge clk);
      #1;
      busy_seen |= busy_o;
    end
    rx = 1'b1;
    for (int i = 0; i < 2 * CPB; i++) begin
      @(posedge clk);
      #1;
      busy_seen |= busy_o;
    end
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_after", busy_o, 0);
    check("glitch_valid_count", n_valid - v0, 0);
    check("glitch_err_count", n_err - e0, 0);
    exp_q.delete();

    // Reset in the middle of bit 4; bits 4..7 and the stop bit of 8'hF5 are
    // high, so the line stays high from reset release to the end of the frame.
    v0 = n_valid;
    e0 = n_err;
    fork
      send_frame(8'hF5, 1'b1, 0);
      begin
        repeat (5 * CPB + HALF) @(posedge clk);
        #1;
        check("pre_reset_busy", busy_o, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midreset_data_o", data_o, 8'h00);
        check("midreset_valid_o", valid_o, 0);
        check("midreset_frame_err_o", frame_err_o, 0);
        check("midreset_busy_o", busy_o, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    idle(2 * CPB);
    check("after_reset_valid_count", n_valid - v0, 0);
    check("after_reset_err_count", n_err - e0, 0);
    check("after_reset_busy", busy_o, 0);
    send_frame(8'h00, 1'b1, 0);
    idle(2 * CPB);
    check("after_reset_frame_valid", n_valid - v0, 1);
    check("after_reset_frame_data", data_o, 8'h00);

    // Random frames: random bytes, occasional bad stop bits, random gaps
    v0 = n_valid;
    e0 = n_err;
    begin
      int want_v, want_e;
      want_v = 0;
      want_e = 0;
      for (int i = 0; i < 40; i++) begin
        logic [7:0] b;
        bit         ok;
        b  = 8'($urandom_range(0, 255));
        ok = ($urandom_range(0, 7) != 0);
        if (ok) want_v++;
        else    want_e++;
        send_frame(b, ok, int'($urandom_range(0, 2)));
        idle(int'($urandom_range(0, CPB)));
      end
      idle(2 * CPB);
      check("random_valid_count", n_valid - v0, want_v);
      check("random_err_count", n_err - e0, want_e);
    end

    // Loopback-style sweep of every byte value, back to back
    v0 = n_valid;
    e0 = n_err;
    for (int v = 0; v < 256; v++) begin
      send_frame(8'(v), 1'b1, 0);
    end
    idle(3 * CPB);
    check("sweep_valid_count", n_valid - v0, 256);
    check("sweep_err_count", n_err - e0, 0);
    check("sweep_last_data", data_o, 8'hFF);
    check("final_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
